// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// The PIPE_CTRL_PERF_EN build option is handled in pipe_ctrl.sv.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    localparam int unsigned ZERO_REG_DEF = 31;
    localparam int unsigned CNT_W        = 32;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/pipe_ctrl_load_use_detect.sv
// Combinational load-use hazard comparator between the ID sources and the EX load destination.
module load_use_detect #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ZERO_REG   = 31
) (
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  loaduse
);

    localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(ZERO_REG);

    logic rs1_hit_s;
    logic rs2_hit_s;

    assign rs1_hit_s = id_uses_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit_s = id_uses_rs2 & (id_rs2 == ex_rd);
    assign loaduse   = id_valid & ex_valid & ex_mem_read & (ex_rd != ZERO_IDX)
                     & (rs1_hit_s | rs2_hit_s);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stage enables and bubble selects for the 5-stage pipe.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned ZERO_REG    = ZERO_REG_DEF,
    parameter int unsigned INIT_CYCLES = 4,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  id_br_taken,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  mem_valid,
    input  logic                  mem_access,
    input  logic                  mem_ready,
    input  logic                  wb_valid,
    input  logic                  wb_is_halt,
    output logic                  pc_wr_en,
    output logic                  ifid_wr_en,
    output logic                  idex_wr_en,
    output logic                  exmem_wr_en,
    output logic                  memwb_wr_en,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic                  exmem_bubble,
    output logic                  memwb_bubble,
    output logic                  halted,
    output logic                  mem_err,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic              TIMEOUT_EN = (MEM_TIMEOUT != 0);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [INIT_W-1:0] init_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              mem_err_r;
    logic              loaduse_s;
    logic              memstall_s;
    logic              active_s;
    logic              timeout_s;
    logic              halt_req_s;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W),
        .ZERO_REG   (ZERO_REG)
    ) u_load_use_detect (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .loaduse     (loaduse_s)
    );

    assign memstall_s = mem_valid & mem_access & ~mem_ready;
    assign active_s   = (state_r == ST_RUN) | (state_r == ST_MEM_WAIT);
    assign halt_req_s = wb_valid & wb_is_halt;
    // wait_cnt_r still holds the count of earlier stall cycles, so LAST marks the final allowed one
    assign timeout_s  = TIMEOUT_EN & active_s & memstall_s & (wait_cnt_r == WAIT_LAST);

    // Next-state and enable/bubble decode from current state and hazard inputs
    always_comb begin
        state_nxt_s  = state_r;
        pc_wr_en     = 1'b0;
        ifid_wr_en   = 1'b0;
        idex_wr_en   = 1'b0;
        exmem_wr_en  = 1'b0;
        memwb_wr_en  = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        memwb_bubble = 1'b0;
        halted       = 1'b0;
        if (reset || (state_r == ST_INIT)) begin
            ifid_wr_en   = 1'b1;
            idex_wr_en   = 1'b1;
            exmem_wr_en  = 1'b1;
            memwb_wr_en  = 1'b1;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
            memwb_bubble = 1'b1;
            if (init_cnt_r == INIT_LAST) begin
                state_nxt_s = ST_RUN;
            end else begin
                state_nxt_s = ST_INIT;
            end
        end else begin
            case (state_r)
                ST_RUN, ST_MEM_WAIT: begin
                    if (memstall_s) begin
                        memwb_wr_en  = 1'b1;
                        memwb_bubble = 1'b1;
                    end else if (loaduse_s) begin
                        idex_wr_en   = 1'b1;
                        idex_bubble  = 1'b1;
                        exmem_wr_en  = 1'b1;
                        memwb_wr_en  = 1'b1;
                    end else begin
                        pc_wr_en     = 1'b1;
                        ifid_wr_en   = 1'b1;
                        idex_wr_en   = 1'b1;
                        exmem_wr_en  = 1'b1;
                        memwb_wr_en  = 1'b1;
                        ifid_flush   = id_br_taken & id_valid;
                    end
                    if (timeout_s || halt_req_s) begin
                        state_nxt_s = ST_HALT;
                    end else if (memstall_s) begin
                        state_nxt_s = ST_MEM_WAIT;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_HALT: begin
                    halted      = 1'b1;
                    state_nxt_s = ST_HALT;
                end
                default: begin
                    state_nxt_s = ST_INIT;
                end
            endcase
        end
    end

    // State register and post-reset clearing counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_INIT;
            init_cnt_r <= {INIT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_INIT) && (init_cnt_r != INIT_LAST)) begin
                init_cnt_r <= init_cnt_r + {{(INIT_W-1){1'b0}}, 1'b1};
            end else begin
                init_cnt_r <= {INIT_W{1'b0}};
            end
        end
    end

    // Consecutive memory-wait counter and sticky timeout error
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
            mem_err_r  <= 1'b0;
        end else begin
            if (active_s && memstall_s) begin
                if (wait_cnt_r != {WAIT_W{1'b1}}) begin
                    wait_cnt_r <= wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
                end else begin
                    wait_cnt_r <= wait_cnt_r;
                end
            end else begin
                wait_cnt_r <= {WAIT_W{1'b0}};
            end
            mem_err_r <= mem_err_r | timeout_s;
        end
    end

    assign mem_err = mem_err_r;
    assign state   = state_r;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Saturating stall and flush event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (active_s && (memstall_s || loaduse_s)) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if ((state_r == ST_RUN) && ifid_flush) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`else
    assign stall_cnt = {CNT_W{1'b0}};
    assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: init, load-use, branch, memory wait, timeout, halt.
module tb_pipe_ctrl;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic        id_br_taken;
    logic        ex_valid;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        mem_valid;
    logic        mem_access;
    logic        mem_ready;
    logic        wb_valid;
    logic        wb_is_halt;
    logic        pc_wr_en, ifid_wr_en, idex_wr_en, exmem_wr_en, memwb_wr_en;
    logic        ifid_flush, idex_bubble, exmem_bubble, memwb_bubble;
    logic        halted;
    logic        mem_err;
    logic [1:0]  state;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    logic [4:0]  en;
    logic [3:0]  bub;
    int          n_checks;
    int          n_fail;
    int          exp_stall;

    assign en  = {pc_wr_en, ifid_wr_en, idex_wr_en, exmem_wr_en, memwb_wr_en};
    assign bub = {ifid_flush, idex_bubble, exmem_bubble, memwb_bubble};

    pipe_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .id_br_taken  (id_br_taken),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .mem_valid    (mem_valid),
        .mem_access   (mem_access),
        .mem_ready    (mem_ready),
        .wb_valid     (wb_valid),
        .wb_is_halt   (wb_is_halt),
        .pc_wr_en     (pc_wr_en),
        .ifid_wr_en   (ifid_wr_en),
        .idex_wr_en   (idex_wr_en),
        .exmem_wr_en  (exmem_wr_en),
        .memwb_wr_en  (memwb_wr_en),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .exmem_bubble (exmem_bubble),
        .memwb_bubble (memwb_bubble),
        .halted       (halted),
        .mem_err      (mem_err),
        .state        (state),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] perf(input int v);
`ifdef PIPE_CTRL_PERF_EN
        return 32'(v);
`else
        return 32'd0;
`endif
    endfunction

    initial begin
        n_checks = 0; n_fail = 0; exp_stall = 0;
        reset = 1'b1;
        id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_br_taken = 1'b0;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
        mem_valid = 1'b0; mem_access = 1'b0; mem_ready = 1'b0;
        wb_valid = 1'b0; wb_is_halt = 1'b0;

        // reset held two cycles
        tick();
        check_eq("rst_en", 32'(en), 32'h0f);
        check_eq("rst_bub", 32'(bub), 32'hf);
        tick();
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_mem_err", 32'(mem_err), 32'd0);
        check_eq("rst_stall_cnt", stall_cnt, 32'd0);

        // four clearing cycles after release, then RUN
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check_eq("init_state", 32'(state), 32'd0);
            check_eq("init_en", 32'(en), 32'h0f);
            check_eq("init_bub", 32'(bub), 32'hf);
            tick();
        end
        check_eq("run_state", 32'(state), 32'd1);
        check_eq("run_en", 32'(en), 32'h1f);
        check_eq("run_bub", 32'(bub), 32'h0);

        // load to x3 in EX, ID reads x3 through rs2
        id_valid = 1'b1; id_uses_rs1 = 1'b1; id_rs1 = 5'd7;
        id_uses_rs2 = 1'b1; id_rs2 = 5'd3;
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3;
        #1;
        check_eq("lu_en", 32'(en), 32'h07);
        check_eq("lu_bub", 32'(bub), 32'h4);
        exp_stall++;
        tick();
        ex_valid = 1'b0; ex_mem_read = 1'b0;
        #1;
        check_eq("lu_after_en", 32'(en), 32'h1f);
        check_eq("lu_after_bub", 32'(bub), 32'h0);
        check_eq("lu_stall_cnt", stall_cnt, perf(exp_stall));

        // zero-register destination and unused source never stall
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd31; id_rs2 = 5'd31;
        #1;
        check_eq("zero_reg_en", 32'(en), 32'h1f);
        ex_rd = 5'd3; id_rs2 = 5'd3; id_uses_rs2 = 1'b0;
        #1;
        check_eq("unused_src_en", 32'(en), 32'h1f);
        tick();

        // load-use and taken branch together: stall first, flush next cycle
        id_uses_rs2 = 1'b1; id_br_taken = 1'b1;
        #1;
        check_eq("lu_br_en", 32'(en), 32'h07);
        check_eq("lu_br_bub", 32'(bub), 32'h4);
        exp_stall++;
        tick();
        ex_valid = 1'b0; ex_mem_read = 1'b0;
        #1;
        check_eq("br_en", 32'(en), 32'h1f);
        check_eq("br_bub", 32'(bub), 32'h8);
        tick();
        id_br_taken = 1'b0; id_valid = 1'b0;
        check_eq("br_flush_cnt", flush_cnt, perf(1));
        check_eq("br_stall_cnt", stall_cnt, perf(exp_stall));

        // store waits 3 cycles; co-pending load-use and branch are suppressed
        mem_valid = 1'b1; mem_access = 1'b1; mem_ready = 1'b0;
        id_valid = 1'b1; ex_valid = 1'b1; ex_mem_read = 1'b1; id_br_taken = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("mw_state", 32'(state), (i == 0) ? 32'd1 : 32'd2);
            check_eq("mw_en", 32'(en), 32'h01);
            check_eq("mw_bub", 32'(bub), 32'h1);
            exp_stall++;
            tick();
        end
        mem_ready = 1'b1;
        id_valid = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0; id_br_taken = 1'b0;
        #1;
        check_eq("mw_release_state", 32'(state), 32'd2);
        check_eq("mw_release_en", 32'(en), 32'h1f);
        check_eq("mw_release_bub", 32'(bub), 32'h0);
        tick();
        check_eq("mw_back_state", 32'(state), 32'd1);
        check_eq("mw_stall_cnt", stall_cnt, perf(exp_stall));

        // memory never ready: halt after 16 stall cycles
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                check_eq("to_last_state", 32'(state), 32'd2);
                check_eq("to_last_err", 32'(mem_err), 32'd0);
            end
            exp_stall++;
            tick();
        end
        check_eq("to_state", 32'(state), 32'd3);
        check_eq("to_mem_err", 32'(mem_err), 32'd1);
        check_eq("to_halted", 32'(halted), 32'd1);
        check_eq("to_en", 32'(en), 32'h00);
        check_eq("to_bub", 32'(bub), 32'h0);
        check_eq("to_stall_cnt", stall_cnt, perf(exp_stall));

        // reset out of HALT clears error and counters
        reset = 1'b1; mem_valid = 1'b0; mem_access = 1'b0;
        tick();
        check_eq("rst2_state", 32'(state), 32'd0);
        check_eq("rst2_mem_err", 32'(mem_err), 32'd0);
        check_eq("rst2_halted", 32'(halted), 32'd0);
        check_eq("rst2_stall_cnt", stall_cnt, 32'd0);
        check_eq("rst2_flush_cnt", flush_cnt, 32'd0);
        reset = 1'b0;
        exp_stall = 0;
        for (int i = 0; i < 4; i++) tick();
        check_eq("rst2_run", 32'(state), 32'd1);

        // HALT retiring alongside a load-use: stall now, halted next cycle
        wb_valid = 1'b1; wb_is_halt = 1'b1;
        id_valid = 1'b1; id_uses_rs2 = 1'b1; id_rs2 = 5'd3;
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3;
        #1;
        check_eq("hlt_cur_en", 32'(en), 32'h07);
        check_eq("hlt_cur_halted", 32'(halted), 32'd0);
        exp_stall++;
        tick();
        wb_valid = 1'b0; wb_is_halt = 1'b0;
        #1;
        check_eq("hlt_state", 32'(state), 32'd3);
        check_eq("hlt_halted", 32'(halted), 32'd1);
        check_eq("hlt_en", 32'(en), 32'h00);
        check_eq("hlt_mem_err", 32'(mem_err), 32'd0);
        mem_valid = 1'b1; mem_access = 1'b1; id_br_taken = 1'b1;
        tick();
        tick();
        check_eq("hlt_hold_en", 32'(en), 32'h00);
        check_eq("hlt_hold_bub", 32'(bub), 32'h0);
        check_eq("hlt_hold_state", 32'(state), 32'd3);
        check_eq("hlt_stall_cnt", stall_cnt, perf(exp_stall));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage processor. Drives the write enables and bubble/flush selects of the PC and the four enable-gated pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB): load-use stalls, taken-branch flush, multi-cycle data-memory waits with timeout, post-reset pipeline clearing and halt. Sits beside the datapath; all outputs go directly to register `wr_en` pins and bubble muxes in the same cycle.

## Interface
- `REG_ADDR_W`, 5, register specifier width
- `ZERO_REG`, 31, hardwired-zero register index, never a hazard source
- `INIT_CYCLES`, 4, post-reset clearing cycles (≥1)
- `MEM_TIMEOUT`, 16, max consecutive memory-wait cycles before halt; 0 disables timeout

- `clk` in 1 — clock, all state updates on rising edge
- `reset` in 1 — synchronous, active-high
- `id_valid` in 1 — ID holds a real instruction
- `id_rs1`, `id_rs2` in REG_ADDR_W — ID source registers
- `id_uses_rs1`, `id_uses_rs2` in 1 — source actually read
- `id_br_taken` in 1 — branch resolved taken in ID
- `ex_valid`, `ex_mem_read` in 1 — EX holds a valid load
- `ex_rd` in REG_ADDR_W — EX destination
- `mem_valid`, `mem_access` in 1 — MEM holds a valid load/store
- `mem_ready` in 1 — data memory completes this cycle
- `wb_valid`, `wb_is_halt` in 1 — HALT instruction retiring
- `pc_wr_en`, `ifid_wr_en`, `idex_wr_en`, `exmem_wr_en`, `memwb_wr_en` out 1
- `ifid_flush`, `idex_bubble`, `exmem_bubble`, `memwb_bubble` out 1 — load a NOP/invalid into that register
- `halted`, `mem_err` out 1
- `state` out 2 — debug
- `stall_cnt`, `flush_cnt` out 32 — perf counters (see Configuration)

## Operation
- States: INIT, RUN, MEM_WAIT, HALT. Outputs decoded combinationally from state + inputs.
- INIT (also while `reset`=1): `pc_wr_en`=0, all stage `wr_en`=1, all bubble/flush=1, `halted`=0. Exits to RUN after INIT_CYCLES cycles with `reset`=0.
- RUN/MEM_WAIT priority, highest first:
  - memstall = `mem_valid & mem_access & !mem_ready`: PC/IFID/IDEX/EXMEM `wr_en`=0; `memwb_wr_en`=1, `memwb_bubble`=1. Load-use and branch suppressed.
  - loaduse = `id_valid & ex_valid & ex_mem_read & ex_rd!=ZERO_REG & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))`: PC/IFID hold; `idex_wr_en`=1 with `idex_bubble`=1; EXMEM/MEMWB advance. Pending branch not flushed; re-evaluated next cycle.
  - `id_br_taken & id_valid`: all `wr_en`=1, `ifid_flush`=1.
  - else: all `wr_en`=1, no bubbles.
- RUN→MEM_WAIT on memstall; MEM_WAIT→RUN on first cycle memstall=0 (that cycle advances normally).
- `wait_cnt` counts consecutive memstall cycles (includes the RUN entry cycle), cleared when memstall=0. If MEM_TIMEOUT≠0 and memstall with `wait_cnt`==MEM_TIMEOUT-1 → HALT, `mem_err` set.
- `wb_valid & wb_is_halt` in RUN/MEM_WAIT → HALT next cycle; current-cycle outputs per priority. Halt and timeout same cycle: HALT, `mem_err`=1.
- HALT: all `wr_en`=0, bubbles 0, `halted`=1; `mem_err` sticky. Exit only via reset.

## Timing
- Zero latency: hazard inputs to enables combinational, same cycle.
- State, `wait_cnt`, `mem_err`, counters registered; reset values INIT, 0, 0, 0.
- Reset mid-stall/mid-halt: next edge → INIT, `mem_err` cleared, `wait_cnt` cleared.
- Exactly one ID/EX bubble per load-use (the load leaves EX at the edge).
- `ex_rd`==ZERO_REG never stalls; unused sources never stall.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: `stall_cnt` increments each RUN/MEM_WAIT cycle with memstall or loaduse; `flush_cnt` increments each cycle `ifid_flush`=1 in RUN; both saturate at 2^32-1, clear on reset.
- Undefined: both outputs constant 0, no counter flops.

## Structure
- `pipe_ctrl_pkg`: state enum (INIT, RUN, MEM_WAIT, HALT; 2-bit encoding driven to `state`), ZERO_REG default, counter width constant.
- Sub-module `load_use_detect`: combinational comparator producing `loaduse`; all sequencing in `pipe_ctrl`.

## Test plan
- Reset held 2 cycles, release, INIT_CYCLES=4 -> `pc_wr_en`=0 and all bubbles=1 for 4 cycles, RUN on 5th, `state` INIT→RUN.
- Load to X3 in EX, ID reads X3 via rs2 -> one cycle `pc_wr_en`=`ifid_wr_en`=0, `idex_bubble`=1; next cycle normal. Same with ex_rd=31 -> no stall.
- Load-use and `id_br_taken` same cycle -> stall only, `ifid_flush`=0; next cycle `ifid_flush`=1.
- Store in MEM, `mem_ready` low 3 cycles -> 3 cycles frozen with `memwb_bubble`=1, MEM_WAIT, return to RUN on ready; `stall_cnt`=3 with PERF_EN.
- MEM_TIMEOUT=16, `mem_ready` never rises -> HALT after 16 stall cycles, `mem_err`=1, all `wr_en`=0; reset clears.
- `wb_is_halt` retires -> `halted`=1 next cycle, enables 0 thereafter, independent of hazard inputs.
